// File: rtl/fir_xifu_pkg.sv
// Shared FIR XIFU definitions: instruction fields, command/response payloads,
// and combinational encoders producing 32-bit custom instructions.
package fir_xifu_pkg;

   localparam int unsigned X_ID_WIDTH = 4;

   localparam logic [6:0] OPCODE_FIR  = 7'b1011011;
   localparam logic [2:0] FUNCT3_LW   = 3'b000;
   localparam logic [2:0] FUNCT3_SW   = 3'b001;
   localparam logic [2:0] FUNCT3_DOTP = 3'b010;
   localparam logic [6:0] FUNCT7_DOTP = 7'b0000000;

   typedef enum logic [1:0] {
      XIFU_LW      = 2'b00,
      XIFU_SW      = 2'b01,
      XIFU_DOTP    = 2'b10,
      XIFU_INVALID = 2'b11
   } fir_xifu_instr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_COMMIT,
      ST_WAIT_RES,
      ST_RESP
   } fir_xifu_state_t;

   typedef struct packed {
      fir_xifu_instr_t op;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [11:0]     imm;
      logic [31:0]     rs1_val;
      logic [31:0]     rs2_val;
   } fir_xifu_cmd_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        err;
   } fir_xifu_rsp_t;

   // Field extractors used by the coprocessor decode side.
   function automatic logic [6:0] xifu_get_opcode(input logic [31:0] instr);
      return instr[6:0];
   endfunction

   function automatic logic [4:0] xifu_get_rd(input logic [31:0] instr);
      return instr[11:7];
   endfunction

   function automatic logic [2:0] xifu_get_funct3(input logic [31:0] instr);
      return instr[14:12];
   endfunction

   function automatic logic [4:0] xifu_get_rs1(input logic [31:0] instr);
      return instr[19:15];
   endfunction

   function automatic logic [4:0] xifu_get_rs2(input logic [31:0] instr);
      return instr[24:20];
   endfunction

   function automatic logic [11:0] xifu_get_imm_i(input logic [31:0] instr);
      return instr[31:20];
   endfunction

   function automatic logic [11:0] xifu_get_imm_s(input logic [31:0] instr);
      return {instr[31:25], instr[11:7]};
   endfunction

   // Encoders: inverse of the extractors above.
   function automatic logic [31:0] xifu_encode_R(input logic [6:0] funct7,
                                                 input logic [4:0] rs2,
                                                 input logic [4:0] rs1,
                                                 input logic [2:0] funct3,
                                                 input logic [4:0] rd,
                                                 input logic [6:0] opcode);
      return {funct7, rs2, rs1, funct3, rd, opcode};
   endfunction

   function automatic logic [31:0] xifu_encode_I(input logic [11:0] imm,
                                                 input logic [4:0]  rs1,
                                                 input logic [2:0]  funct3,
                                                 input logic [4:0]  rd,
                                                 input logic [6:0]  opcode);
      return {imm, rs1, funct3, rd, opcode};
   endfunction

   function automatic logic [31:0] xifu_encode_S(input logic [11:0] imm,
                                                 input logic [4:0]  rs2,
                                                 input logic [4:0]  rs1,
                                                 input logic [2:0]  funct3,
                                                 input logic [6:0]  opcode);
      return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
   endfunction

   // Map an abstract command onto its instruction word.
   function automatic logic [31:0] fir_xifu_encode(input fir_xifu_cmd_t cmd);
      logic [31:0] instr;
      instr = '0;
      case (cmd.op)
         XIFU_LW:   instr = xifu_encode_I(cmd.imm, cmd.rs1, FUNCT3_LW, cmd.rd, OPCODE_FIR);
         XIFU_SW:   instr = xifu_encode_S(cmd.imm, cmd.rs2, cmd.rs1, FUNCT3_SW, OPCODE_FIR);
         XIFU_DOTP: instr = xifu_encode_R(FUNCT7_DOTP, cmd.rs2, cmd.rs1, FUNCT3_DOTP,
                                          cmd.rd, OPCODE_FIR);
         default:   instr = '0;
      endcase
      return instr;
   endfunction

endpackage

// File: rtl/fir_xifu_offloader.sv
// Core-side initiator for the FIR X-interface coprocessor: encodes commands,
// runs issue/commit/result handshakes, one instruction in flight.
// Optional result timeout: define FIR_XIFU_OFFLOADER_TIMEOUT_EN.
module fir_xifu_offloader
   import fir_xifu_pkg::*;
`ifdef FIR_XIFU_OFFLOADER_TIMEOUT_EN
   #(
      parameter int unsigned TIMEOUT_CYCLES = 64
   )
`endif
   (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [1:0]            cmd_op_i,
   input  logic [4:0]            cmd_rs1_i,
   input  logic [4:0]            cmd_rs2_i,
   input  logic [4:0]            cmd_rd_i,
   input  logic [11:0]           cmd_imm_i,
   input  logic [31:0]           cmd_rs1_val_i,
   input  logic [31:0]           cmd_rs2_val_i,
   output logic                  x_issue_valid_o,
   input  logic                  x_issue_ready_i,
   output logic [31:0]           x_issue_instr_o,
   output logic [X_ID_WIDTH-1:0] x_issue_id_o,
   output logic [31:0]           x_issue_rs0_o,
   output logic [31:0]           x_issue_rs1_o,
   input  logic                  x_issue_accept_i,
   input  logic                  x_issue_writeback_i,
   output logic                  x_commit_valid_o,
   output logic [X_ID_WIDTH-1:0] x_commit_id_o,
   output logic                  x_commit_kill_o,
   input  logic                  x_result_valid_i,
   output logic                  x_result_ready_o,
   input  logic [X_ID_WIDTH-1:0] x_result_id_i,
   input  logic [4:0]            x_result_rd_i,
   input  logic [31:0]           x_result_data_i,
   input  logic                  x_result_we_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_data_o,
   output logic [4:0]            rsp_rd_o,
   output logic                  rsp_we_o,
   output logic                  rsp_err_o
);

`ifdef FIR_XIFU_OFFLOADER_TIMEOUT_EN
   localparam int unsigned TMR_W        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
   // Stale results from timed-out transactions are drained while idle.
   localparam logic        IDLE_READY   = 1'b1;
   logic [TMR_W-1:0] timer;
`else
   localparam logic        IDLE_READY   = 1'b0;
`endif

   fir_xifu_state_t       state;
   logic [X_ID_WIDTH-1:0] id_cnt;
   logic                  writeback_q;
   logic [4:0]            rd_q;
   fir_xifu_rsp_t         rsp_q;
   fir_xifu_cmd_t         cmd_c;

   // Gather command inputs into one payload for the encoder.
   always_comb begin
      cmd_c         = '0;
      cmd_c.op      = fir_xifu_instr_t'(cmd_op_i);
      cmd_c.rs1     = cmd_rs1_i;
      cmd_c.rs2     = cmd_rs2_i;
      cmd_c.rd      = cmd_rd_i;
      cmd_c.imm     = cmd_imm_i;
      cmd_c.rs1_val = cmd_rs1_val_i;
      cmd_c.rs2_val = cmd_rs2_val_i;
   end

   assign x_commit_kill_o = 1'b0;
   assign rsp_data_o      = rsp_q.data;
   assign rsp_rd_o        = rsp_q.rd;
   assign rsp_we_o        = rsp_q.we;
   assign rsp_err_o       = rsp_q.err;

   // Transaction FSM with all handshake outputs registered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state            <= ST_IDLE;
         id_cnt           <= '0;
         writeback_q      <= 1'b0;
         rd_q             <= '0;
         cmd_ready_o      <= 1'b1;
         x_issue_valid_o  <= 1'b0;
         x_issue_instr_o  <= '0;
         x_issue_id_o     <= '0;
         x_issue_rs0_o    <= '0;
         x_issue_rs1_o    <= '0;
         x_commit_valid_o <= 1'b0;
         x_commit_id_o    <= '0;
         x_result_ready_o <= 1'b0;
         rsp_valid_o      <= 1'b0;
         rsp_q            <= '0;
`ifdef FIR_XIFU_OFFLOADER_TIMEOUT_EN
         timer            <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               x_result_ready_o <= IDLE_READY;
               // cmd_ready_o is high for the whole of IDLE
               if (cmd_valid_i) begin
                  cmd_ready_o      <= 1'b0;
                  x_result_ready_o <= 1'b0;
                  rd_q             <= cmd_rd_i;
                  if (cmd_c.op == XIFU_INVALID) begin
                     rsp_valid_o <= 1'b1;
                     rsp_q       <= '{data: 32'h0, rd: cmd_rd_i, we: 1'b0, err: 1'b1};
                     state       <= ST_RESP;
                  end else begin
                     x_issue_valid_o <= 1'b1;
                     x_issue_instr_o <= fir_xifu_encode(cmd_c);
                     x_issue_id_o    <= id_cnt;
                     x_issue_rs0_o   <= cmd_c.rs1_val;
                     x_issue_rs1_o   <= cmd_c.rs2_val;
                     state           <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE: begin
               if (x_issue_ready_i) begin
                  x_issue_valid_o <= 1'b0;
                  id_cnt          <= id_cnt + X_ID_WIDTH'(1);
                  writeback_q     <= x_issue_writeback_i;
                  if (x_issue_accept_i) begin
                     x_commit_valid_o <= 1'b1;
                     x_commit_id_o    <= x_issue_id_o;
                     state            <= ST_COMMIT;
                  end else begin
                     rsp_valid_o <= 1'b1;
                     rsp_q       <= '{data: 32'h0, rd: rd_q, we: 1'b0, err: 1'b1};
                     state       <= ST_RESP;
                  end
               end
            end

            ST_COMMIT: begin
               x_commit_valid_o <= 1'b0;
               if (writeback_q) begin
                  x_result_ready_o <= 1'b1;
                  state            <= ST_WAIT_RES;
`ifdef FIR_XIFU_OFFLOADER_TIMEOUT_EN
                  timer            <= '0;
`endif
               end else begin
                  rsp_valid_o <= 1'b1;
                  rsp_q       <= '{data: 32'h0, rd: rd_q, we: 1'b0, err: 1'b0};
                  state       <= ST_RESP;
               end
            end

            ST_WAIT_RES: begin
               // x_result_ready_o is high for the whole of WAIT_RES
               if (x_result_valid_i) begin
                  x_result_ready_o <= 1'b0;
                  rsp_valid_o      <= 1'b1;
                  rsp_q            <= '{data: x_result_data_i,
                                        rd:   x_result_rd_i,
                                        we:   x_result_we_i,
                                        err:  (x_result_id_i != x_issue_id_o)};
                  state            <= ST_RESP;
               end
`ifdef FIR_XIFU_OFFLOADER_TIMEOUT_EN
               else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  x_result_ready_o <= 1'b0;
                  rsp_valid_o      <= 1'b1;
                  rsp_q            <= '{data: TIMEOUT_DATA, rd: rd_q, we: 1'b0, err: 1'b1};
                  state            <= ST_RESP;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
`endif
            end

            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o      <= 1'b0;
                  cmd_ready_o      <= 1'b1;
                  x_result_ready_o <= IDLE_READY;
                  state            <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_xifu_offloader.sv
// Self-checking bench for fir_xifu_offloader: directed table, hand sequences
// for reset/ID wrap/timeout, and randomized commands against a simple model.
module tb_fir_xifu_offloader;
   import fir_xifu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
   logic [11:0] cmd_imm;
   logic [31:0] cmd_rs1_val, cmd_rs2_val;
   logic        iss_valid, iss_ready, iss_accept, iss_wb;
   logic [31:0] iss_instr, iss_rs0, iss_rs1;
   logic [3:0]  iss_id, com_id, res_id;
   logic        com_valid, com_kill;
   logic        res_valid, res_ready, res_we;
   logic [4:0]  res_rd;
   logic [31:0] res_data;
   logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;

   always #5 clk = ~clk;

   fir_xifu_offloader dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
      .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2), .cmd_rd_i(cmd_rd), .cmd_imm_i(cmd_imm),
      .cmd_rs1_val_i(cmd_rs1_val), .cmd_rs2_val_i(cmd_rs2_val),
      .x_issue_valid_o(iss_valid), .x_issue_ready_i(iss_ready), .x_issue_instr_o(iss_instr),
      .x_issue_id_o(iss_id), .x_issue_rs0_o(iss_rs0), .x_issue_rs1_o(iss_rs1),
      .x_issue_accept_i(iss_accept), .x_issue_writeback_i(iss_wb),
      .x_commit_valid_o(com_valid), .x_commit_id_o(com_id), .x_commit_kill_o(com_kill),
      .x_result_valid_i(res_valid), .x_result_ready_o(res_ready), .x_result_id_i(res_id),
      .x_result_rd_i(res_rd), .x_result_data_i(res_data), .x_result_we_i(res_we),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .rsp_rd_o(rsp_rd), .rsp_we_o(rsp_we), .rsp_err_o(rsp_err)
   );

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  rs1, rs2, rd;
      logic [11:0] imm;
      logic [31:0] v1, v2;
      logic        accept, wb, bad_id;
      logic [4:0]  res_rd;
      logic [31:0] res_data;
      logic        res_we;
      int          issue_wait, rsp_wait;
      logic [31:0] exp_instr, exp_data;
      logic [4:0]  exp_rd;
      logic        exp_we, exp_err, chk_data;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_id = 0;
   int commit_pulses = 0;
   int rready_cycles = 0;
   vec_t vecs[7];

   // Count commit pulses and result-ready cycles as seen by the peer.
   always @(negedge clk) begin
      if (com_valid) commit_pulses++;
      if (res_ready) rready_cycles++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Instruction word from field positions, using plain arithmetic.
   function automatic logic [31:0] model_instr(input int unsigned op, input int unsigned rs1,
                                               input int unsigned rs2, input int unsigned rd,
                                               input int unsigned imm);
      int unsigned w;
      case (op)
         0: w = imm * 1048576 + rs1 * 32768 + 0 * 4096 + rd * 128 + 91;
         1: w = (imm / 32) * 33554432 + rs2 * 1048576 + rs1 * 32768 + 1 * 4096
                + (imm % 32) * 128 + 91;
         2: w = rs2 * 1048576 + rs1 * 32768 + 2 * 4096 + rd * 128 + 91;
         default: w = 0;
      endcase
      return 32'(w);
   endfunction

   function automatic vec_t model_expect(input vec_t v);
      vec_t r = v;
      r.exp_instr = model_instr(32'(v.op), 32'(v.rs1), 32'(v.rs2), 32'(v.rd), 32'(v.imm));
      r.exp_data = 32'h0; r.exp_rd = 5'h0; r.chk_data = 1'b0; r.exp_we = 1'b0;
      if (v.op == 2'b11 || !v.accept) r.exp_err = 1'b1;
      else if (!v.wb) r.exp_err = 1'b0;
      else begin
         r.exp_err = v.bad_id; r.exp_we = v.res_we; r.exp_data = v.res_data;
         r.exp_rd = v.res_rd; r.chk_data = 1'b1;
      end
      return r;
   endfunction

   function automatic vec_t mkv(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [11:0] imm,
                                input logic [31:0] v1, input logic [31:0] v2,
                                input logic accept, input logic wb, input logic bad_id,
                                input logic [4:0] res_rd, input logic [31:0] res_data,
                                input logic res_we, input int iw, input int rw,
                                input logic [31:0] exp_instr, input logic [31:0] exp_data,
                                input logic [4:0] exp_rd, input logic exp_we,
                                input logic exp_err, input logic chk);
      vec_t v;
      v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.v1 = v1; v.v2 = v2;
      v.accept = accept; v.wb = wb; v.bad_id = bad_id; v.res_rd = res_rd;
      v.res_data = res_data; v.res_we = res_we; v.issue_wait = iw; v.rsp_wait = rw;
      v.exp_instr = exp_instr; v.exp_data = exp_data; v.exp_rd = exp_rd;
      v.exp_we = exp_we; v.exp_err = exp_err; v.chk_data = chk;
      return v;
   endfunction

   task automatic drive_cmd(input vec_t v);
      int n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      check("cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_op = v.op; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2; cmd_rd = v.rd;
      cmd_imm = v.imm; cmd_rs1_val = v.v1; cmd_rs2_val = v.v2;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // One full transaction with this bench acting as both peer and requester.
   task automatic do_txn(input vec_t v);
      int n;
      int c0 = commit_pulses;
      int r0 = rready_cycles;
      logic [3:0] id_now;
      drive_cmd(v);
      if (v.op != 2'b11) begin
         check("issue_valid", 32'(iss_valid), 32'd1);
         check("issue_instr", iss_instr, v.exp_instr);
         check("issue_id", 32'(iss_id), 32'(exp_id));
         check("issue_rs0", iss_rs0, v.v1);
         check("issue_rs1", iss_rs1, v.v2);
         for (int i = 0; i < v.issue_wait; i++) begin
            @(negedge clk);
            check("issue_hold_valid", 32'(iss_valid), 32'd1);
            check("issue_hold_instr", iss_instr, v.exp_instr);
            check("issue_hold_rs0", iss_rs0, v.v1);
         end
         id_now = 4'(exp_id);
         iss_ready = 1'b1; iss_accept = v.accept; iss_wb = v.wb;
         @(negedge clk);
         iss_ready = 1'b0;
         exp_id = (exp_id + 1) % 16;
         check("issue_drop", 32'(iss_valid), 32'd0);
         if (v.accept) begin
            check("commit_valid", 32'(com_valid), 32'd1);
            check("commit_id", 32'(com_id), 32'(id_now));
            check("commit_kill", 32'(com_kill), 32'd0);
            if (v.wb) begin
               n = 0;
               while (!res_ready && n < 20) begin @(negedge clk); n++; end
               check("result_ready", 32'(res_ready), 32'd1);
               res_valid = 1'b1; res_id = v.bad_id ? (id_now ^ 4'd1) : id_now;
               res_rd = v.res_rd; res_data = v.res_data; res_we = v.res_we;
               @(negedge clk);
               res_valid = 1'b0;
            end
         end
      end else begin
         check("invalid_no_issue", 32'(iss_valid), 32'd0);
      end
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < v.rsp_wait; i++) begin
         @(negedge clk);
         check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
         check("rsp_hold_err", 32'(rsp_err), 32'(v.exp_err));
      end
      check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      check("rsp_we", 32'(rsp_we), 32'(v.exp_we));
      if (v.chk_data) begin
         check("rsp_data", rsp_data, v.exp_data);
         check("rsp_rd", 32'(rsp_rd), 32'(v.exp_rd));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_drop", 32'(rsp_valid), 32'd0);
      check("commit_count", 32'(commit_pulses - c0), 32'((v.op != 2'b11 && v.accept) ? 1 : 0));
`ifndef FIR_XIFU_OFFLOADER_TIMEOUT_EN
      if (!(v.op != 2'b11 && v.accept && v.wb))
         check("no_result_ready", 32'(rready_cycles - r0), 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
      cmd_imm = '0; cmd_rs1_val = '0; cmd_rs2_val = '0; iss_ready = 1'b0; iss_accept = 1'b0;
      iss_wb = 1'b0; res_valid = 1'b0; res_id = '0; res_rd = '0; res_data = '0; res_we = 1'b0;
      rsp_ready = 1'b0;

      // Directed vectors: op rs1 rs2 rd imm v1 v2 acc wb bad rrd rdata rwe iw rw | expected
      vecs[0] = mkv(2'b10, 5'd11, 5'd12, 5'd10, 12'h000, 32'd3, 32'd4, 1, 1, 0, 5'd10,
                    32'h0000000C, 1, 0, 0, 32'h00C5A55B, 32'h0000000C, 5'd10, 1, 0, 1);
      vecs[1] = mkv(2'b00, 5'd6, 5'd0, 5'd5, 12'h004, 32'h100, 32'h0, 1, 1, 0, 5'd5,
                    32'h12345678, 1, 0, 0, 32'h004302DB, 32'h12345678, 5'd5, 1, 0, 1);
      vecs[2] = mkv(2'b01, 5'd8, 5'd7, 5'd0, 12'h010, 32'h200, 32'h77, 1, 0, 0, 5'd0,
                    32'h0, 0, 0, 0, 32'h0074185B, 32'h0, 5'd0, 0, 0, 0);
      vecs[3] = mkv(2'b10, 5'd2, 5'd3, 5'd1, 12'h000, 32'hAAAA, 32'h5555, 1, 1, 0, 5'd1,
                    32'h0000A5A5, 0, 5, 3, 32'h003120DB, 32'h0000A5A5, 5'd1, 0, 0, 1);
      vecs[4] = mkv(2'b00, 5'd4, 5'd0, 5'd3, 12'hFFF, 32'h1, 32'h2, 0, 1, 0, 5'd0,
                    32'h0, 0, 2, 0, 32'hFFF201DB, 32'h0, 5'd0, 0, 1, 0);
      vecs[5] = mkv(2'b11, 5'd1, 5'd2, 5'd3, 12'h123, 32'h1, 32'h2, 1, 1, 0, 5'd0,
                    32'h0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 1, 0);
      vecs[6] = mkv(2'b01, 5'd31, 5'd31, 5'd9, 12'hFFF, 32'hFFFF, 32'h1, 1, 1, 1, 5'd9,
                    32'hCAFEF00D, 1, 0, 1, 32'hFFFF9FDB, 32'hCAFEF00D, 5'd9, 1, 1, 1);

      // Reset state while reset is held
      @(negedge clk); @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_issue_valid", 32'(iss_valid), 32'd0);
      check("rst_commit_valid", 32'(com_valid), 32'd0);
      check("rst_result_ready", 32'(res_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_instr", iss_instr, 32'h0);
      check("rst_issue_id", 32'(iss_id), 32'd0);
      check("rst_rsp_data", rsp_data, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) do_txn(vecs[i]);

      // Reset while waiting for a result abandons the transaction
      v = model_expect(mkv(2'b10, 5'd1, 5'd1, 5'd1, 12'h0, 32'h1, 32'h1, 1, 1, 0, 5'd0,
                           32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive_cmd(v);
      iss_ready = 1'b1; iss_accept = 1'b1; iss_wb = 1'b1;
      @(negedge clk);
      iss_ready = 1'b0;
      n = 0;
      while (!res_ready && n < 20) begin @(negedge clk); n++; end
      check("pre_rst_result_ready", 32'(res_ready), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_result_ready", 32'(res_ready), 32'd0);
      check("midrst_issue_valid", 32'(iss_valid), 32'd0);
      check("midrst_commit_valid", 32'(com_valid), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n = commit_pulses;
      repeat (6) @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      check("post_rst_no_commit", 32'(commit_pulses - n), 32'd0);
      exp_id = 0;

      // 17 back-to-back commands exercise the ID wrap 15 -> 0
      for (int i = 0; i < 17; i++) begin
         v = model_expect(mkv(2'b10, 5'(i), 5'(i + 1), 5'(i + 2), 12'h0, 32'(i), 32'(2 * i),
                              1, 1, 0, 5'(i + 2), 32'(i * 7), 1, 0, 0, 0, 0, 0, 0, 0, 0));
         do_txn(v);
      end
      check("id_wrapped", 32'(exp_id), 32'd1);

      // Randomized commands against the model
      for (int i = 0; i < 40; i++) begin
         int unsigned sel = $urandom_range(0, 9);
         v.op = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
         v.rs1 = 5'($urandom); v.rs2 = 5'($urandom); v.rd = 5'($urandom);
         v.imm = 12'($urandom); v.v1 = $urandom; v.v2 = $urandom;
         v.accept = ($urandom_range(0, 7) != 0); v.wb = 1'($urandom);
         v.bad_id = ($urandom_range(0, 7) == 0);
         v.res_rd = 5'($urandom); v.res_data = $urandom; v.res_we = 1'($urandom);
         v.issue_wait = $urandom_range(0, 3); v.rsp_wait = $urandom_range(0, 3);
         v = model_expect(v);
         do_txn(v);
      end

`ifdef FIR_XIFU_OFFLOADER_TIMEOUT_EN
      // No result ever arrives: timeout response, then a stale result is drained
      v = model_expect(mkv(2'b00, 5'd1, 5'd0, 5'd2, 12'h8, 32'h1, 32'h0, 1, 1, 0, 5'd0,
                           32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive_cmd(v);
      iss_ready = 1'b1; iss_accept = 1'b1; iss_wb = 1'b1;
      @(negedge clk);
      iss_ready = 1'b0;
      n = 0;
      while (!res_ready && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
      check("timeout_cycles", 32'(n), 32'd64);
      check("timeout_err", 32'(rsp_err), 32'd1);
      check("timeout_data", rsp_data, 32'hDEADBEEF);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      @(negedge clk);
      check("idle_stale_ready", 32'(res_ready), 32'd1);
      res_valid = 1'b1; res_id = 4'(exp_id); res_data = 32'h1234;
      @(negedge clk);
      res_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("stale_dropped", 32'(rsp_valid), 32'd0);
      exp_id = (exp_id + 1) % 16;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
